// File: rtl/par2ser_stream.sv
// -----------------------------------------------------------------------------
// par2ser_stream
//   Accepts DATA_W-bit words from a parallel producer on a req/grant handshake,
//   holds up to DEPTH of them in a circular buffer and streams them out one bit
//   per clock, back-to-back with no idle cycle between consecutive words.
//
// Parameters
//   DATA_W     parallel word width (>=2)
//   DEPTH      buffer depth in words (power of 2, >=2)
//   LSB_FIRST  0: bit DATA_W-1 leaves first; 1: bit 0 leaves first
//
// Optional build macro
//   PARITY_EN  when defined, each frame is followed by one even-parity bit
//              (XOR of the word), making a frame DATA_W+1 cycles long.
//
// Ports
//   p_clk             clock, rising edge
//   n_rst             asynchronous reset, active low
//   req               producer offers parallel_data_in this cycle
//   parallel_data_in  word to serialise
//   grant             buffer can take a word this cycle (registered)
//   serial_data_out   current serial bit, 0 whenever out_data is 0
//   out_data          serial_data_out carries a valid bit
//   frame_start       one-cycle pulse alongside the first bit of each word
//   fill_level        words waiting in the buffer (word being shifted excluded)
// -----------------------------------------------------------------------------
module par2ser_stream #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic                   p_clk,
  input  logic                   n_rst,
  input  logic                   req,
  input  logic [DATA_W-1:0]      parallel_data_in,
  output logic                   grant,
  output logic                   serial_data_out,
  output logic                   out_data,
  output logic                   frame_start,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [BC_W-1:0]  LAST_IDX_C = BC_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  // Bit that leaves the shifter next, according to the configured bit order.
  function automatic logic lead_bit(input logic [DATA_W-1:0] w);
    if (LSB_FIRST != 0) begin
      return w[0];
    end else begin
      return w[DATA_W-1];
    end
  endfunction

  // Drop the bit just sent so the next one sits at the lead position.
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    if (LSB_FIRST != 0) begin
      return w >> 1'b1;
    end else begin
      return w << 1'b1;
    end
  endfunction

`ifdef PARITY_EN
  // Even parity over the whole word: the appended bit makes the total 1-count even.
  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              grant_r;
  logic [1:0]        state_r;
  logic [DATA_W-1:0] shreg_r;
  logic [BC_W-1:0]   bit_cnt_r;
  logic              serial_r;
  logic              valid_r;
  logic              fs_r;
`ifdef PARITY_EN
  logic              parity_r;
`endif

  logic              push_s;
  logic              ready_s;
  logic              pop_s;
  logic [DATA_W-1:0] head_s;

  // Handshake decode and pop decision; a pop may happen on the final bit of a
  // frame so that the next word follows without a gap.
  always_comb begin
    push_s  = req & grant_r;
    head_s  = mem_r[rd_ptr_r];
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE:   ready_s = 1'b1;
`ifdef PARITY_EN
      ST_SHIFT:  ready_s = 1'b0;
      ST_PARITY: ready_s = 1'b1;
`else
      ST_SHIFT:  ready_s = (bit_cnt_r == {BC_W{1'b0}});
`endif
      default:   ready_s = 1'b0;
    endcase
    pop_s       = ready_s & (count_r != {CNT_W{1'b0}});
    count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Buffer storage; contents need no reset because count_r qualifies them.
  always_ff @(posedge p_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= parallel_data_in;
    end
  end

  // Pointers, fill count, grant and the serialiser state machine.
  always_ff @(posedge p_clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      grant_r   <= 1'b0;
      state_r   <= ST_IDLE;
      shreg_r   <= {DATA_W{1'b0}};
      bit_cnt_r <= {BC_W{1'b0}};
      serial_r  <= 1'b0;
      valid_r   <= 1'b0;
      fs_r      <= 1'b0;
`ifdef PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      count_r <= count_nxt_s;
      // Grant looks at the post-edge count, so a full buffer never sees a push.
      grant_r <= (count_nxt_s < DEPTH_C);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end

      if (pop_s) begin
        // Load: the first bit goes straight to the output register.
        state_r   <= ST_SHIFT;
        shreg_r   <= advance(head_s);
        bit_cnt_r <= LAST_IDX_C;
        serial_r  <= lead_bit(head_s);
        valid_r   <= 1'b1;
        fs_r      <= 1'b1;
`ifdef PARITY_EN
        parity_r  <= even_parity(head_s);
`endif
      end else begin
        fs_r <= 1'b0;
        case (state_r)
          ST_SHIFT: begin
            if (bit_cnt_r != {BC_W{1'b0}}) begin
              shreg_r   <= advance(shreg_r);
              bit_cnt_r <= bit_cnt_r - BC_W'(1'b1);
              serial_r  <= lead_bit(shreg_r);
              valid_r   <= 1'b1;
            end else begin
`ifdef PARITY_EN
              state_r  <= ST_PARITY;
              serial_r <= parity_r;
              valid_r  <= 1'b1;
`else
              state_r  <= ST_IDLE;
              serial_r <= 1'b0;
              valid_r  <= 1'b0;
`endif
            end
          end
`ifdef PARITY_EN
          ST_PARITY: begin
            state_r  <= ST_IDLE;
            serial_r <= 1'b0;
            valid_r  <= 1'b0;
          end
`endif
          ST_IDLE: begin
            state_r  <= ST_IDLE;
            serial_r <= 1'b0;
            valid_r  <= 1'b0;
          end
          default: begin
            state_r  <= ST_IDLE;
            serial_r <= 1'b0;
            valid_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign grant           = grant_r;
  assign serial_data_out = serial_r;
  assign out_data        = valid_r;
  assign frame_start     = fs_r;
  assign fill_level      = count_r;

endmodule
